// File: rtl/dg0045_rom_fetch_seq.sv
// Instruction fetch sequencer for the DG0045 core: rebuilds the 10-bit PC from the
// multiplexed PC_HL bus and fetches the opcode byte over a req/ack memory handshake.
module dg0045_rom_fetch_seq #(
  parameter bit REUSE  = 1'b1,
  parameter int MISS_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [4:0]        pc_hl,
  output logic              pc_mux,
  output logic              rom_req,
  output logic [9:0]        rom_addr,
  input  logic              rom_ack,
  input  logic [7:0]        rom_data,
  output logic [7:0]        rom_byte,
  output logic [MISS_W-1:0] miss_cnt,
  output logic [2:0]        phase
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CAPLO = 3'd1,
    CAPHI = 3'd2,
    REQ   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [MISS_W-1:0] MISS_MAX = '1;
  localparam logic [MISS_W-1:0] MISS_ONE = {{(MISS_W-1){1'b0}}, 1'b1};

  state_t      state;
  logic [4:0]  addr_lo;
  logic [4:0]  addr_hi;
  logic [9:0]  last_addr;
  logic        last_valid;
  logic [9:0]  next_addr;
  logic        hit;

  assign rom_addr  = {addr_hi, addr_lo};
  // The hit test uses the high half arriving on this very edge.
  assign next_addr = {pc_hl, addr_lo};
  assign hit       = REUSE && last_valid && (next_addr == last_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= 3'd0;
      pc_mux     <= 1'b0;
      rom_req    <= 1'b0;
      addr_lo    <= 5'd0;
      addr_hi    <= 5'd0;
      rom_byte   <= 8'h00;
      miss_cnt   <= '0;
      last_addr  <= 10'd0;
      last_valid <= 1'b0;
    end else if (ena) begin
      phase  <= phase + 3'd1;
      pc_mux <= (phase == 3'd6);
      case (state)
        IDLE: begin
          if (phase == 3'd5) state <= CAPLO;
        end
        CAPLO: begin
          if (phase == 3'd6) begin
            addr_lo <= pc_hl;
            state   <= CAPHI;
          end
        end
        CAPHI: begin
          if (phase == 3'd7) begin
            addr_hi <= pc_hl;
            if (hit) begin
              state <= DONE;
            end else begin
              state   <= REQ;
              rom_req <= 1'b1;
            end
          end
        end
        REQ: begin
          // An ack on the deadline edge still wins over the miss.
          if (rom_ack) begin
            rom_byte   <= rom_data;
            last_addr  <= rom_addr;
            last_valid <= 1'b1;
            rom_req    <= 1'b0;
            state      <= DONE;
          end else if (phase == 3'd2) begin
            rom_byte   <= 8'h00;
            last_valid <= 1'b0;
            if (miss_cnt != MISS_MAX) miss_cnt <= miss_cnt + MISS_ONE;
            rom_req    <= 1'b0;
            state      <= DONE;
          end
        end
        DONE: begin
          if (phase >= 3'd2 && phase <= 3'd4) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          rom_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dg0045_rom_fetch_seq.sv
// Self-checking bench for dg0045_rom_fetch_seq: table of fetch vectors with a
// scoreboard queue, plus hand-written saturation, ena-gating and reset sequences.
module tb_dg0045_rom_fetch_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [9:0] cur_pc;
  logic [4:0] pc_hl, nr_pc_hl;
  logic       pc_mux, rom_req, rom_ack;
  logic [9:0] rom_addr;
  logic [7:0] rom_data, rom_byte, miss_cnt;
  logic [2:0] phase;
  logic       nr_pc_mux, nr_req;
  logic [9:0] nr_addr;
  logic [7:0] nr_byte, nr_miss;
  logic [2:0] nr_phase;

  typedef struct {
    logic [9:0] pc;
    int         k;        // 0: no ack, 1..3: ack sampled k clks after req, 4: late ack
    logic [7:0] data;
    logic       hit;
    logic [7:0] exp_byte;
    logic [7:0] exp_miss;
  } vec_t;

  typedef struct {
    logic [9:0] addr;
    logic [7:0] rbyte;
    logic [7:0] miss;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[9];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Core model: the PC_HL bus shows the half selected by pc_mux.
  assign pc_hl    = pc_mux    ? cur_pc[9:5] : cur_pc[4:0];
  assign nr_pc_hl = nr_pc_mux ? cur_pc[9:5] : cur_pc[4:0];

  dg0045_rom_fetch_seq #(.REUSE(1'b1), .MISS_W(8)) dut (
    .clk(clk), .rst(rst), .ena(ena), .pc_hl(pc_hl), .pc_mux(pc_mux),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
    .rom_byte(rom_byte), .miss_cnt(miss_cnt), .phase(phase)
  );

  dg0045_rom_fetch_seq #(.REUSE(1'b0), .MISS_W(8)) dut_nr (
    .clk(clk), .rst(rst), .ena(ena), .pc_hl(nr_pc_hl), .pc_mux(nr_pc_mux),
    .rom_req(nr_req), .rom_addr(nr_addr), .rom_ack(rom_ack), .rom_data(rom_data),
    .rom_byte(nr_byte), .miss_cnt(nr_miss), .phase(nr_phase)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One machine cycle, entered at the start of phase 6 and left at the next phase 6.
  task automatic do_fetch(input vec_t v);
    exp_t       e;
    logic [2:0] mask, want;
    chk("phase_at_start", phase, 3'd6);
    cur_pc  = v.pc;
    e.addr  = v.pc;
    e.rbyte = v.exp_byte;
    e.miss  = v.exp_miss;
    sbq.push_back(e);
    tick();
    chk("pc_mux_ph7", pc_mux, 1'b1);
    tick();
    chk("pc_mux_ph0", pc_mux, 1'b0);
    chk("noreuse_req_ph0", nr_req, 1'b1);
    for (int p = 0; p < 3; p++) begin
      mask[p] = rom_req;
      want[p] = !v.hit && (v.k == 0 || v.k > p);
      if (v.k == p + 1) begin
        rom_ack  = 1'b1;
        rom_data = v.data;
      end
      tick();
      rom_ack  = 1'b0;
      rom_data = 8'h00;
    end
    chk("req_mask", mask, want);
    chk("phase3", phase, 3'd3);
    if (v.k == 4) begin
      rom_ack  = 1'b1;
      rom_data = v.data;
    end
    if (sbq.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      chk("rom_addr", rom_addr, e.addr);
      chk("rom_byte", rom_byte, e.rbyte);
      chk("miss_cnt", miss_cnt, e.miss);
      chk("req_low_ph3", rom_req, 1'b0);
    end
    tick();
    rom_ack  = 1'b0;
    rom_data = 8'h00;
    chk("byte_stable_3to4", rom_byte, e.rbyte);
    chk("miss_after_ph3", miss_cnt, e.miss);
    tick();
    tick();
  endtask

  initial begin
    vec_t v;
    logic [7:0] m;
    rst = 1'b1; ena = 1'b1; cur_pc = 10'd0; rom_ack = 1'b0; rom_data = 8'h00;

    //           pc       k  data   hit   byte   miss
    tbl[0] = '{10'h2A5, 2, 8'h8C, 1'b0, 8'h8C, 8'h00};  // nominal
    tbl[1] = '{10'h100, 0, 8'h00, 1'b0, 8'h00, 8'h01};  // deadline
    tbl[2] = '{10'h100, 4, 8'h77, 1'b0, 8'h00, 8'h02};  // late ack, re-request after miss
    tbl[3] = '{10'h155, 3, 8'h41, 1'b0, 8'h41, 8'h02};  // ack on deadline edge
    tbl[4] = '{10'h3C0, 1, 8'h5E, 1'b0, 8'h5E, 8'h02};
    tbl[5] = '{10'h3C0, 2, 8'h99, 1'b1, 8'h5E, 8'h02};  // reuse hit, stray ack ignored
    tbl[6] = '{10'h3FF, 1, 8'hFF, 1'b0, 8'hFF, 8'h02};
    tbl[7] = '{10'h000, 3, 8'h12, 1'b0, 8'h12, 8'h02};
    tbl[8] = '{10'h000, 1, 8'h34, 1'b1, 8'h12, 8'h02};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_byte", rom_byte, 8'h00);
    chk("rst_req", rom_req, 1'b0);
    chk("rst_addr", rom_addr, 10'h000);
    chk("rst_pc_mux", pc_mux, 1'b0);
    chk("rst_miss", miss_cnt, 8'h00);
    chk("rst_phase", phase, 3'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("first_cycle_no_req", rom_req, 1'b0);
      tick();
    end

    for (int i = 0; i < 9; i++) do_fetch(tbl[i]);

    // Saturating miss counter.
    m = 8'h02;
    for (int i = 0; i < 300; i++) begin
      m = (m != 8'hFF) ? m + 8'h01 : 8'hFF;
      v = '{10'h2B4, 0, 8'h00, 1'b0, 8'h00, m};
      do_fetch(v);
    end
    chk("miss_saturated", miss_cnt, 8'hFF);

    // ena dropped in phase 1 with a request pending.
    cur_pc = 10'h0AB;
    tick(); tick(); tick();
    chk("ena_pre_phase", phase, 3'd1);
    chk("ena_pre_req", rom_req, 1'b1);
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ena_hold_phase", phase, 3'd1);
      chk("ena_hold_req", rom_req, 1'b1);
      chk("ena_hold_addr", rom_addr, 10'h0AB);
    end
    ena = 1'b1;
    tick();
    chk("ena_resume_phase", phase, 3'd2);
    rom_ack = 1'b1; rom_data = 8'h6D;
    tick();
    rom_ack = 1'b0; rom_data = 8'h00;
    chk("ena_ack_byte", rom_byte, 8'h6D);
    chk("ena_ack_miss", miss_cnt, 8'hFF);
    chk("ena_ack_req", rom_req, 1'b0);
    tick(); tick(); tick();

    // Reset pulsed in phase 1 of a pending request.
    cur_pc = 10'h1C3;
    tick(); tick(); tick();
    chk("rst_mid_pre_req", rom_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_req", rom_req, 1'b0);
    chk("rst_mid_byte", rom_byte, 8'h00);
    chk("rst_mid_miss", miss_cnt, 8'h00);
    #1 rst = 1'b0;
    #1;
    chk("rst_rel_phase", phase, 3'd0);
    chk("rst_rel_req", rom_req, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    chk("rst_rel_no_early_req", rom_req, 1'b0);
    v = '{10'h1C3, 1, 8'h22, 1'b0, 8'h22, 8'h00};
    do_fetch(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dg0045_rom_fetch_seq.md
# dg0045_rom_fetch_seq

Off-core instruction fetch sequencer for the DG0045 4-bit core. It reconstructs the 10-bit program counter from the core's 5-bit multiplexed PC_HL bus by driving PC_MUX, then fetches the opcode byte from a variable-latency program memory over a req/ack handshake. It presents that byte on the core's ui_in so the byte is stable when the core latches its instruction at the end of machine-cycle phase 3. The block runs on the core clock and tracks the core's 8-clock machine cycle with its own phase counter, released from reset together with the core.

## Interface
- REUSE, default 1: when 1, a fetch whose address equals the last successfully fetched address skips the memory request and re-presents the held byte.
- MISS_W, default 8: width of the saturating miss counter.
- clk  in  1  core clock, rising edge; identical to the core's clk.
- rst  in  1  reset, asynchronous, active-high.
- ena  in  1  advance enable; same signal as the core's ena. When low, all state freezes.
- pc_hl  in  5  core PC_HL bus (core uo_out[4:0]).
- pc_mux  out  1  to core PC_MUX (uio_in[5]). 0 selects PL[4:0]; 1 selects {PU, PL[5]}.
- rom_req  out  1  memory request level.
- rom_addr  out  10  request address {PU, PL}, stable while rom_req=1.
- rom_ack  in  1  memory data valid, single-cycle.
- rom_data  in  8  memory data, valid in the rom_ack cycle.
- rom_byte  out  8  opcode to core ui_in.
- miss_cnt  out  MISS_W  saturating count of deadline misses.
- phase  out  3  current machine-cycle phase, 0..7.

## Operation
- Phase counter:
  - Reset value 0.
  - Increments mod 8 on each clk edge with ena=1.
  - Mirrors the core clock_divider.
- pc_mux:
  - Registered.
  - 1 during phase 7 only; 0 in all other phases.
  - Reset value 0.
- Address capture:
  - At the edge ending phase 6 (pc_mux=0), pc_hl goes into addr_lo[4:0].
  - At the edge ending phase 7 (pc_mux=1), pc_hl goes into addr_hi[4:0].
  - rom_addr = {addr_hi, addr_lo}.
  - The core's PC is stable from the start of phase 6 through the end of phase 1, so both captures see the same PC.
- FSM states: IDLE, CAPLO, CAPHI, REQ, DONE.
  - IDLE → CAPLO on entering phase 6.
  - CAPLO → CAPHI on entering phase 7.
  - CAPHI → REQ on entering phase 0, unless REUSE=1, last_valid=1 and the address equals last_addr. In that case CAPHI → DONE (hit) and rom_byte is unchanged.
  - REQ → DONE on a sampled rom_ack, or at the edge ending phase 2 (deadline).
  - DONE → IDLE on entering phase 3.
- rom_req:
  - 1 exactly while in REQ.
  - Drops on the edge where ack is sampled, or at the deadline edge.
  - rom_ack while not in REQ is ignored.
- On ack in REQ:
  - rom_byte ← rom_data.
  - last_addr ← rom_addr; last_valid ← 1.
- On deadline without ack:
  - rom_byte ← 0x00 (NOP).
  - last_valid ← 0.
  - miss_cnt increments, saturating at all-ones.
- rom_byte changes only on the edges ending phases 0, 1 or 2. It is constant across the 3→4 edge.
- Reset values: rom_byte=0x00, rom_req=0, rom_addr=0, pc_mux=0, miss_cnt=0, phase=0, last_valid=0, state IDLE.

## Timing
- Capture-to-request latency is 1 clk: rom_req rises at the start of phase 0.
- Memory latency budget: ack may be sampled at the edge ending phase 0, 1 or 2, i.e. 1 to 3 clks after rom_req rises. A later ack counts as a miss.
- ack and deadline on the same edge (ack sampled at the end of phase 2): the ack wins and no miss is counted.
- ena=0 mid-request:
  - phase, FSM and rom_req are held.
  - The deadline is measured in ena-qualified phases, not raw clks.
- rst asserted mid-request:
  - rom_req drops immediately (asynchronous).
  - All registers take their reset values.
  - The first cycle after release is phase 0 with no request outstanding.
- The first fetch after reset starts in phase 6. This matches the core ignoring its first machine cycle (CLKEN low).
- Back-to-back cycles: DONE → IDLE → CAPLO with no dead machine cycles. Throughput is one fetch per 8 ena-clks.

## Test plan
- Nominal fetch: PC=0x2A5 with memory ack 2 clks after req and rom_data=0x8C → rom_addr=0x2A5; rom_req high for phases 0–1; rom_byte=0x8C from the end of phase 1 and stable across the 3→4 edge; miss_cnt=0.
- Deadline: ack withheld → rom_req falls at the end of phase 2; rom_byte=0x00; miss_cnt=1. An ack arriving in phase 3 is ignored. 300 consecutive misses with MISS_W=8 → miss_cnt=0xFF.
- Boundary ack: ack sampled exactly at the end of phase 2 with data 0x41 → rom_byte=0x41; miss_cnt unchanged.
- Reuse: two consecutive cycles at PC=0x3C0, the first acked with 0x5E → second cycle has no rom_req pulse and rom_byte stays 0x5E. With REUSE=0 the second cycle issues a request. After a miss, the same address re-requests.
- ena gating: ena dropped for 5 clks in phase 1 with req pending → phase, rom_req and rom_addr are frozen. After resume, an ack at the next phase 2 is accepted.
- Reset mid-request: rst pulsed in phase 1 → rom_req=0 and rom_byte=0x00 immediately. After release, phase=0, and the first request appears at the phase 0 following capture.
